// File: rtl/repacker_ctrl_pkg.sv
// Shared definitions for the repacker line controller: FSM state encoding
// and the default width of the line-length / word counters.
package repacker_ctrl_pkg;

    localparam int DEF_WORDS_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2,
        ST_FLUSH  = 2'd3
    } line_state_e;

endpackage

// File: rtl/repacker_line_ctrl.sv
// Line controller in front of a word repacker: primes the repacker, streams
// one line of words to a valid/ready sink, then flushes the repacker buffer.
module repacker_line_ctrl
    import repacker_ctrl_pkg::*;
#(
    parameter int WORDS_W = DEF_WORDS_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               line_start,
    input  logic [WORDS_W-1:0] line_words,
    input  logic [3:0]         line_last_strb,
    input  logic               abort,
    output logic               rep_enable,
    output logic               rep_data_req,
    input  logic [31:0]        rep_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [31:0]        tx_data,
    output logic [3:0]         tx_strb,
    output logic               tx_last,
    output logic               busy,
    output logic               line_done,
    output logic               start_err
);

    localparam logic [WORDS_W-1:0] ONE_WORD = WORDS_W'(1);

    line_state_e        state_q, state_d;
    logic [WORDS_W-1:0] remaining_q, remaining_d;
    logic [3:0]         last_strb_q, last_strb_d;
    logic               rep_enable_q, rep_enable_d;
    logic               tx_valid_q, tx_valid_d;
    logic               busy_q, busy_d;
    logic               line_done_q, line_done_d;
    logic               start_err_q, start_err_d;
    logic               handshake;
    logic               last_word;

    assign last_word = tx_valid_q && (remaining_q == ONE_WORD);
    assign handshake = tx_valid_q && tx_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        last_strb_d = last_strb_q;
        line_done_d = 1'b0;
        start_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (line_start) begin
                    if (line_words != '0) begin
                        remaining_d = line_words;
                        last_strb_d = line_last_strb;
                        state_d     = ST_PRIME;
                    end else begin
                        start_err_d = 1'b1;
                    end
                end
            end
            ST_PRIME: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                // The guard keeps the counter from wrapping even if the sink misbehaves.
                if (handshake && (remaining_q != '0)) begin
                    remaining_d = remaining_q - ONE_WORD;
                    if (last_word) begin
                        state_d     = ST_FLUSH;
                        line_done_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((state_q != ST_IDLE) && line_start) begin
            start_err_d = 1'b1;
        end

        // Abort wins over everything: no completion, no rejection pulse, counter dropped.
        if ((state_q != ST_IDLE) && abort) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
            line_done_d = 1'b0;
            start_err_d = 1'b0;
        end

        rep_enable_d = (state_d == ST_PRIME) || (state_d == ST_STREAM);
        tx_valid_d   = (state_d == ST_STREAM);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            last_strb_q  <= '0;
            rep_enable_q <= 1'b0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            line_done_q  <= 1'b0;
            start_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            last_strb_q  <= last_strb_d;
            rep_enable_q <= rep_enable_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            line_done_q  <= line_done_d;
            start_err_q  <= start_err_d;
        end
    end

    assign rep_enable   = rep_enable_q;
    assign tx_valid     = tx_valid_q;
    assign busy         = busy_q;
    assign line_done    = line_done_q;
    assign start_err    = start_err_q;
    assign tx_last      = last_word;
    assign rep_data_req = handshake && !last_word;
    assign tx_data      = tx_valid_q ? rep_data : 32'h0;
    assign tx_strb      = !tx_valid_q ? 4'h0 : (last_word ? last_strb_q : 4'hF);

endmodule

// File: tb/tb_repacker_line_ctrl.sv
// Bench for repacker_line_ctrl with a behavioural repacker and a word scoreboard.
module tb_repacker_line_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_start = 1'b0;
    logic [15:0] line_words = '0;
    logic [3:0]  line_last_strb = '0;
    logic        abort = 1'b0;
    logic        rep_enable;
    logic        rep_data_req;
    logic [31:0] rep_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_data;
    logic [3:0]  tx_strb;
    logic        tx_last;
    logic        busy;
    logic        line_done;
    logic        start_err;

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;
    logic [7:0] line_id = 8'h00;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic        l;
    } exp_t;
    exp_t exp_q[$];

    repacker_line_ctrl #(.WORDS_W(16)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .line_words(line_words),
        .line_last_strb(line_last_strb), .abort(abort), .rep_enable(rep_enable),
        .rep_data_req(rep_data_req), .rep_data(rep_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_strb(tx_strb), .tx_last(tx_last),
        .busy(busy), .line_done(line_done), .start_err(start_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [7:0] id, input int w);
        logic [15:0] w16;
        w16 = w[15:0];
        return {id, 8'hA5, w16};
    endfunction

    // Repacker model: loads word 0 one cycle after enable, advances one cycle after data_req.
    logic primed = 1'b0;
    int   ptr = 0;
    always @(posedge clk) begin
        if (!rep_enable) begin
            primed   <= 1'b0;
            ptr      <= 0;
            rep_data <= 32'h0;
        end else if (!primed) begin
            primed   <= 1'b1;
            rep_data <= mk(line_id, 0);
            ptr      <= 1;
        end else if (rep_data_req) begin
            rep_data <= mk(line_id, ptr);
            ptr      <= ptr + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_line(input int n, input logic [3:0] s, input logic [7:0] id);
        exp_t e;
        for (int w = 0; w < n; w++) begin
            e.d = mk(id, w);
            e.s = (w == n - 1) ? s : 4'hF;
            e.l = (w == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            tick();
            @(negedge clk);
            if (line_done) seen = 1'b1;
        end
        check("line_done_seen", 64'(seen), 64'd1);
    endtask

    task automatic start_line(input logic [15:0] n, input logic [3:0] s);
        line_start     = 1'b1;
        line_words     = n;
        line_last_strb = s;
    endtask

    // Scoreboard monitor: every accepted word is popped and compared.
    always @(negedge clk) begin
        if (!rst && !abort && tx_valid && tx_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h want none", tx_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("tx_word", {27'h0, tx_last, tx_strb, tx_data}, {27'h0, e.l, e.s, e.d});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] held;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_outputs", {rep_enable, rep_data_req, tx_valid, tx_last, busy, line_done,
                              start_err, tx_strb, tx_data}, 64'h0);
        tick();
        rst = 1'b0;

        // Line of 4, strobe 0011, sink always ready
        tick();
        line_id = 8'h01;
        push_line(4, 4'b0011, 8'h01);
        tx_ready = 1'b1;
        start_line(16'd4, 4'b0011);
        @(negedge clk);
        check("t1_idle_busy", {tx_valid, busy}, 64'h0);
        tick();
        line_start = 1'b0;
        @(negedge clk);
        check("t1_prime", {rep_enable, tx_valid, rep_data_req, busy}, 64'b1001);
        for (int i = 2; i <= 5; i++) begin
            tick();
            @(negedge clk);
            check("t1_stream", {tx_valid, tx_last, rep_data_req}, {61'h0, 1'b1, (i == 5), (i != 5)});
        end
        tick();
        @(negedge clk);
        check("t1_flush", {line_done, rep_enable, tx_valid, busy}, 64'b1001);
        tick();
        @(negedge clk);
        check("t1_idle_after", {line_done, busy}, 64'h0);
        check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // Line of 3 with a 2-cycle stall on word 2
        base = hs_cnt;
        tick();
        line_id = 8'h02;
        push_line(3, 4'hF, 8'h02);
        start_line(16'd3, 4'hF);
        tick();
        line_start = 1'b0;
        tick();
        tick();
        tx_ready = 1'b0;
        @(negedge clk);
        held = tx_data;
        check("t2_stall_data", 64'(tx_data), 64'(mk(8'h02, 1)));
        check("t2_stall_req0", 64'(rep_data_req), 64'd0);
        tick();
        @(negedge clk);
        check("t2_stall_hold", {31'h0, tx_valid, tx_data}, {31'h0, 1'b1, held});
        check("t2_stall_req1", 64'(rep_data_req), 64'd0);
        tick();
        tx_ready = 1'b1;
        wait_done(10);
        check("t2_handshakes", 64'(hs_cnt - base), 64'd3);
        tick();

        // Zero-length line rejected
        tick();
        start_line(16'd0, 4'h1);
        tick();
        line_start = 1'b0;
        @(negedge clk);
        check("t3_err_pulse", {start_err, busy}, 64'b10);
        tick();
        @(negedge clk);
        check("t3_err_clear", {start_err, busy}, 64'b00);

        // line_start during STREAM is rejected and leaves the count alone
        base = hs_cnt;
        tick();
        line_id = 8'h03;
        push_line(4, 4'b1000, 8'h03);
        start_line(16'd4, 4'b1000);
        tick();
        line_start = 1'b0;
        tick();
        tick();
        start_line(16'd7, 4'h1);
        tick();
        line_start = 1'b0;
        @(negedge clk);
        check("t4_busy_err", {start_err, busy}, 64'b11);
        wait_done(10);
        check("t4_handshakes", 64'(hs_cnt - base), 64'd4);
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // Abort during word 2 of 5, then a normal line
        tick();
        line_id = 8'h04;
        push_line(5, 4'h1, 8'h04);
        start_line(16'd5, 4'h1);
        tick();
        line_start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        @(negedge clk);
        check("t5_word2_shown", 64'(tx_valid), 64'd1);
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("t5_after_abort", {busy, rep_enable, tx_valid, line_done}, 64'h0);
        check("t5_words_left", 64'(exp_q.size()), 64'd4);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("t5_no_done", {line_done, busy}, 64'h0);
        end
        tick();
        line_id = 8'h05;
        push_line(2, 4'b0110, 8'h05);
        start_line(16'd2, 4'b0110);
        tick();
        line_start = 1'b0;
        wait_done(10);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();

        // Reset mid-STREAM, then a single-word line
        tick();
        line_id = 8'h06;
        push_line(4, 4'hF, 8'h06);
        start_line(16'd4, 4'hF);
        tick();
        line_start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_outputs", {rep_enable, rep_data_req, tx_valid, tx_last, busy, line_done,
                                 start_err, tx_strb, tx_data}, 64'h0);
        exp_q.delete();
        tick();
        line_id = 8'h07;
        push_line(1, 4'b0111, 8'h07);
        start_line(16'd1, 4'b0111);
        tick();
        line_start = 1'b0;
        tick();
        @(negedge clk);
        check("t6_single_last", {tx_valid, tx_last, tx_strb}, {58'h0, 1'b1, 1'b1, 4'b0111});
        wait_done(5);
        check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/repacker_line_ctrl.md
REPACKER_LINE_CTRL -- requirements
Module: repacker_line_ctrl

Interface
REQ-001 SHALL have parameter WORDS_W, default 16, width of line length and word counters.
REQ-002 SHALL have ports as follows (clock and reset first):
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- line_start  in  1  one-cycle pulse, begin one line.
- line_words  in  WORDS_W  words in the line, sampled with line_start.
- line_last_strb  in  4  byte-valid pattern for the final word, sampled with line_start.
- abort  in  1  terminate current line immediately.
- rep_enable  out  1  drives repacker enable.
- rep_data_req  out  1  drives repacker data_req (advance one word).
- rep_data  in  32  repacker data_out.
- tx_valid  out  1  word available to sink.
- tx_ready  in  1  sink accepts word.
- tx_data  out  32  word to sink.
- tx_strb  out  4  byte enables of tx_data.
- tx_last  out  1  final word of line.
- busy  out  1  line in progress.
- line_done  out  1  one-cycle pulse, line completed.
- start_err  out  1  one-cycle pulse, line_start rejected.

Function
REQ-003 SHALL implement FSM states IDLE, PRIME, STREAM, FLUSH.
REQ-004 IDLE: rep_enable=0, tx_valid=0, busy=0; line_start with line_words!=0 SHALL latch line_words into remaining and line_last_strb into a register, then go to PRIME.
REQ-005 IDLE: line_start with line_words==0 SHALL stay IDLE and pulse start_err the next cycle.
REQ-006 PRIME: exactly one cycle; rep_enable=1, tx_valid=0, rep_data_req=0 (repacker loads its buffer); then STREAM.
REQ-007 STREAM: rep_enable=1, tx_valid=1, tx_data=rep_data combinationally.
REQ-008 STREAM: a handshake (tx_valid & tx_ready) SHALL decrement remaining by 1.
REQ-009 rep_data_req SHALL equal tx_valid & tx_ready & ~tx_last, so the next word is present the following cycle.
REQ-010 tx_data SHALL hold stable while tx_valid & ~tx_ready.
REQ-011 tx_last SHALL be 1 in STREAM when remaining==1.
REQ-012 tx_strb SHALL be the latched last strobe when tx_last=1, else 4'hF.
REQ-013 Handshake with tx_last=1 SHALL go to FLUSH.
REQ-014 FLUSH: one cycle; rep_enable=0 (repacker clears buffer), line_done=1; then IDLE.
REQ-015 busy SHALL be 1 in PRIME, STREAM, FLUSH.
REQ-016 line_start while busy SHALL be ignored and SHALL pulse start_err the next cycle.
REQ-017 line_start in the same cycle as the FLUSH->IDLE transition SHALL be treated as busy (rejected).
REQ-018 abort in any non-IDLE state SHALL go to IDLE next cycle with rep_enable=0, no line_done, no further handshakes.
REQ-019 abort has priority over handshake and over line_start in the same cycle.
REQ-020 abort in IDLE SHALL have no effect.
REQ-021 line_words = 2^WORDS_W-1 SHALL stream without counter wrap; remaining SHALL never underflow.
REQ-022 line_words==1 SHALL give tx_last=1 on the first STREAM word.
REQ-023 Latency SHALL be: line_start cycle T, PRIME T+1, first tx_valid T+2.
REQ-024 Throughput SHALL be one word per cycle with tx_ready held high.

Reset
REQ-025 rst SHALL force IDLE; all outputs 0 (tx_strb 0); remaining and latched strobe cleared.
REQ-026 rst mid-line SHALL behave as abort without line_done; rep_enable SHALL be 0 the cycle after rst is sampled.

Structure
REQ-027 A shared package repacker_ctrl_pkg SHALL hold the FSM state enum and the default WORDS_W constant.
REQ-028 The block is a single module with no sub-modules; it instantiates no repacker (connected at the parent).

Verification
REQ-029 Bench SHALL drive a repacker behaviour model (1-cycle load after enable/data_req) and cover:
- line_words=4, strb 4'b0011, tx_ready=1 -> tx_valid T+2..T+5; strb F,F,F,3; tx_last at T+5; line_done T+6.
- line_words=3, tx_ready low for 2 cycles on word 2 -> tx_data stable, rep_data_req=0 while stalled; 3 handshakes total.
- line_words=0 -> start_err pulse; busy stays 0.
- line_start during STREAM -> start_err; word count unaffected.
- abort during word 2 of 5 -> IDLE next cycle, rep_enable=0, no line_done; a new line then runs normally.
- rst asserted mid-STREAM -> all outputs 0 next cycle; line_words=1 after reset -> single word with tx_last=1.
